phase_decoder: RTL and testbench

Downstream consumer of the four-phase clock generator. Runs on the system clock `clk_in`, samples the phase levels clkA..clkD as ordinary synchronous inputs, and checks that their rising edges arrive in the order B→C→D→A. It captures the CarbonCore serial result bit in the clkC window, shifts it in on the clkD window, and presents assembled words with a one-cycle valid strobe. It also flags phase-order and stall errors.

---
 rtl/phase_decoder_pkg.sv | 19 +
 rtl/phase_decoder_edge_det.sv | 22 ++
 rtl/phase_decoder.sv | 135 +++++++++++++
 tb/tb_phase_decoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/phase_decoder_pkg.sv
// Shared types and constants for the four-phase decoder and the clock generator's bench.
package phase_decoder_pkg;

   typedef enum logic [1:0] {
      ST_WAIT_B = 2'd0,
      ST_WAIT_C = 2'd1,
      ST_WAIT_D = 2'd2,
      ST_WAIT_A = 2'd3
   } state_e;

   localparam int PH_A = 0;
   localparam int PH_B = 1;
   localparam int PH_C = 2;
   localparam int PH_D = 3;

   localparam int PHASE_PERIOD  = 32;
   localparam int PHASE_SPACING = 8;

endpackage

// File: rtl/phase_decoder_edge_det.sv
// Rise detector for the four phase levels: compares each level with its previous-cycle value.
module phase_edge_det (
   input  logic       clk_in,
   input  logic       reset,
   input  logic [3:0] lvl,
   output logic [3:0] rise
);

   logic [3:0] lvl_q;

   // Previous-cycle phase levels
   always_ff @(posedge clk_in) begin
      if (reset) begin
         lvl_q <= 4'b0000;
      end else begin
         lvl_q <= lvl;
      end
   end

   assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/phase_decoder.sv
// Tracks the B->C->D->A phase order, assembles serial core bits into words and
// flags order violations and stalls.
module phase_decoder
   import phase_decoder_pkg::*;
#(
   parameter int WORD_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                         clk_in,
   input  logic                         reset,
   input  logic                         clkA,
   input  logic                         clkB,
   input  logic                         clkC,
   input  logic                         clkD,
   input  logic                         core_out,
   input  logic                         clear_err,
   output logic [WORD_W-1:0]            word_out,
   output logic                         word_valid,
   output logic [$clog2(WORD_W+1)-1:0]  bit_count,
   output logic                         phase_err
);

   localparam int CW = $clog2(WORD_W + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_BIT  = CW'(WORD_W - 1);
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

   logic [3:0]        lvl_s;
   logic [3:0]        rise_s;
   logic [3:0]        exp_mask_s;
   logic              exp_rise_s;
   logic              rise_err_s;
   logic              idle_s;
   logic              timeout_s;
   logic              err_s;
   state_e            state_adv_s;
   state_e            recover_s;
   logic [TW-1:0]     timer_d;
   logic [WORD_W-1:0] shift_d;

   state_e            state_q;
   logic [TW-1:0]     timer_q;
   logic [WORD_W-1:0] shreg_q;
   logic              cap_q;
   logic [WORD_W-1:0] word_q;
   logic              valid_q;
   logic [CW-1:0]     count_q;
   logic              err_q;

   assign lvl_s = {clkD, clkC, clkB, clkA};

   phase_edge_det u_edge (
      .clk_in (clk_in),
      .reset  (reset),
      .lvl    (lvl_s),
      .rise   (rise_s)
   );

   // Expected-phase decode, error and stall detection
   always_comb begin
      exp_mask_s  = 4'b0000;
      state_adv_s = ST_WAIT_C;
      case (state_q)
         ST_WAIT_B: begin exp_mask_s[PH_B] = 1'b1; state_adv_s = ST_WAIT_C; end
         ST_WAIT_C: begin exp_mask_s[PH_C] = 1'b1; state_adv_s = ST_WAIT_D; end
         ST_WAIT_D: begin exp_mask_s[PH_D] = 1'b1; state_adv_s = ST_WAIT_A; end
         ST_WAIT_A: begin exp_mask_s[PH_A] = 1'b1; state_adv_s = ST_WAIT_B; end
         default:   begin exp_mask_s[PH_B] = 1'b1; state_adv_s = ST_WAIT_C; end
      endcase
      // An exact one-hot match is required, so simultaneous rises count as errors
      exp_rise_s = (rise_s == exp_mask_s);
      rise_err_s = (rise_s != 4'b0000) && !exp_rise_s;
      idle_s     = (state_q == ST_WAIT_B) && (count_q == '0);
      timer_d    = timer_q + TW'(1);
      timeout_s  = !exp_rise_s && !idle_s && (timer_d == TIMER_MAX);
      err_s      = rise_err_s || timeout_s;
      recover_s  = (rise_s == 4'b0010) ? ST_WAIT_C : ST_WAIT_B;
      shift_d    = {shreg_q[WORD_W-2:0], cap_q};
   end

   // Phase FSM, bit capture, word assembly and sticky error
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q <= ST_WAIT_B;
         timer_q <= '0;
         shreg_q <= '0;
         cap_q   <= 1'b0;
         word_q  <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (err_s) begin
            err_q   <= 1'b1;
            shreg_q <= '0;
            count_q <= '0;
            cap_q   <= 1'b0;
            timer_q <= '0;
            state_q <= recover_s;
         end else begin
            if (clear_err) begin
               err_q <= 1'b0;
            end
            if (exp_rise_s) begin
               timer_q <= '0;
               state_q <= state_adv_s;
               if (state_q == ST_WAIT_C) begin
                  cap_q <= core_out;
               end
               if (state_q == ST_WAIT_D) begin
                  shreg_q <= shift_d;
                  if (count_q == LAST_BIT) begin
                     word_q  <= shift_d;
                     valid_q <= 1'b1;
                     count_q <= '0;
                  end else begin
                     count_q <= count_q + CW'(1);
                  end
               end
            end else if (idle_s) begin
               timer_q <= '0;
            end else begin
               timer_q <= timer_d;
            end
         end
      end
   end

   assign word_out   = word_q;
   assign word_valid = valid_q;
   assign bit_count  = count_q;
   assign phase_err  = err_q;

endmodule

// File: tb/tb_phase_decoder.sv
// Self-checking bench for phase_decoder: directed phase scenarios plus a random soak,
// compared every cycle against a queue-based reference model.
module tb_phase_decoder;
   import phase_decoder_pkg::*;

   localparam int W  = 8;
   localparam int TO = 16;

   logic clk_in = 1'b0;
   logic reset, clkA, clkB, clkC, clkD, core_out, clear_err;
   logic [W-1:0] word_out;
   logic         word_valid;
   logic [$clog2(W+1)-1:0] bit_count;
   logic         phase_err;

   int checks   = 0;
   int failures = 0;
   int vcount   = 0;

   logic [3:0]   m_prev;
   int           m_pos;
   bit           m_bits[$];
   logic         m_cap;
   logic [W-1:0] m_word;
   logic         m_valid;
   logic         m_err;
   int           m_timer;
   int           seq[4] = '{PH_B, PH_C, PH_D, PH_A};

   always #5 clk_in = ~clk_in;

   phase_decoder #(.WORD_W(W), .TIMEOUT(TO)) dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .clkA       (clkA),
      .clkB       (clkB),
      .clkC       (clkC),
      .clkD       (clkD),
      .core_out   (core_out),
      .clear_err  (clear_err),
      .word_out   (word_out),
      .word_valid (word_valid),
      .bit_count  (bit_count),
      .phase_err  (phase_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      logic [3:0]   lvl, rise;
      logic [W-1:0] w;
      int           n, ph;
      logic         good, bad, tmo;
      lvl     = {clkD, clkC, clkB, clkA};
      m_valid = 1'b0;
      if (reset) begin
         m_prev = 4'b0000; m_pos = 0; m_bits.delete(); m_cap = 1'b0;
         m_word = '0; m_err = 1'b0; m_timer = 0;
      end else begin
         rise = lvl & ~m_prev;
         n    = $countones(rise);
         ph   = seq[m_pos];
         good = (n == 1) && rise[ph];
         bad  = (n > 0) && !good;
         tmo  = 1'b0;
         if (good) begin
            m_timer = 0;
            if (ph == PH_C) m_cap = core_out;
            if (ph == PH_D) begin
               m_bits.push_back(m_cap);
               if (m_bits.size() == W) begin
                  w = '0;
                  foreach (m_bits[i]) w = (w << 1) | W'(m_bits[i]);
                  m_word  = w;
                  m_valid = 1'b1;
                  m_bits.delete();
               end
            end
            m_pos = (m_pos + 1) % 4;
         end else if (!bad) begin
            if (m_pos == 0 && m_bits.size() == 0) begin
               m_timer = 0;
            end else begin
               m_timer++;
               tmo = (m_timer == TO);
            end
         end
         if (bad || tmo) begin
            m_err = 1'b1; m_bits.delete(); m_cap = 1'b0; m_timer = 0;
            m_pos = (n == 1 && rise[PH_B]) ? 1 : 0;
         end else if (clear_err) begin
            m_err = 1'b0;
         end
      end
      m_prev = lvl;
   endtask

   task automatic cyc(input logic [3:0] lvl, input logic core, input logic clr, input logic rst);
      {clkD, clkC, clkB, clkA} = lvl;
      core_out  = core;
      clear_err = clr;
      reset     = rst;
      @(posedge clk_in);
      model_step();
      #1;
      if (word_valid === 1'b1) vcount++;
      chk("word_out",   32'(word_out),   32'(m_word));
      chk("word_valid", 32'(word_valid), 32'(m_valid));
      chk("bit_count",  32'(bit_count),  32'(m_bits.size()));
      chk("phase_err",  32'(phase_err),  32'(m_err));
   endtask

   // One generator period carrying bit b; core_out is noise except at the clkC rise
   task automatic period(input logic b);
      repeat (PHASE_SPACING) cyc(4'b0010, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      cyc(4'b0100, b, 1'b0, 1'b0);
      repeat (PHASE_SPACING - 1) cyc(4'b0100, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      repeat (PHASE_SPACING) cyc(4'b1000, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      repeat (PHASE_SPACING) cyc(4'b0001, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
   endtask

   initial begin
      logic [W-1:0] pat;
      logic [3:0]   lvl_r;
      int           v0;

      // Reset state
      repeat (2) cyc(4'b0000, 1'b0, 1'b0, 1'b1);
      chk("rst_word", 32'(word_out), 32'h0);
      chk("rst_valid", 32'(word_valid), 32'h0);
      chk("rst_count", 32'(bit_count), 32'h0);
      chk("rst_err", 32'(phase_err), 32'h0);

      // Nominal word 1,0,1,1,0,0,1,0
      pat = 8'hB2;
      for (int i = W - 1; i >= 0; i--) period(pat[i]);
      chk("nom_word", 32'(word_out), 32'hB2);
      chk("nom_pulses", 32'(vcount), 32'd1);
      chk("nom_err", 32'(phase_err), 32'h0);

      // Out of order: D after B
      repeat (2) cyc(4'b0000, 1'b0, 1'b0, 1'b0);
      cyc(4'b0010, 1'b0, 1'b0, 1'b0);
      cyc(4'b1010, 1'b0, 1'b0, 1'b0);
      chk("ooo_err", 32'(phase_err), 32'h1);
      chk("ooo_count", 32'(bit_count), 32'h0);
      chk("ooo_word", 32'(word_out), 32'hB2);
      cyc(4'b0000, 1'b0, 1'b1, 1'b0);
      chk("ooo_clear", 32'(phase_err), 32'h0);

      // Simultaneous C and D in WAIT_C, then a clean random word
      cyc(4'b0010, 1'b0, 1'b0, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0, 1'b0);
      cyc(4'b1100, 1'b0, 1'b0, 1'b0);
      chk("sim_err", 32'(phase_err), 32'h1);
      cyc(4'b0000, 1'b0, 1'b1, 1'b0);
      v0  = vcount;
      pat = W'($urandom);
      for (int i = W - 1; i >= 0; i--) period(pat[i]);
      chk("sim_word", 32'(word_out), 32'(pat));
      chk("sim_pulses", 32'(vcount - v0), 32'd1);

      // Stall after a clkB rise
      cyc(4'b0000, 1'b0, 1'b0, 1'b0);
      cyc(4'b0010, 1'b0, 1'b0, 1'b0);
      repeat (TO - 1) cyc(4'b0000, 1'b0, 1'b0, 1'b0);
      chk("stall_pre", 32'(phase_err), 32'h0);
      cyc(4'b0000, 1'b0, 1'b0, 1'b0);
      chk("stall_err", 32'(phase_err), 32'h1);
      cyc(4'b0000, 1'b0, 1'b1, 1'b0);
      repeat (100) cyc(4'b0000, 1'b0, 1'b0, 1'b0);
      chk("idle_err", 32'(phase_err), 32'h0);

      // Clear racing an out-of-order rise
      cyc(4'b0010, 1'b0, 1'b0, 1'b0);
      cyc(4'b1010, 1'b0, 1'b1, 1'b0);
      chk("race_err", 32'(phase_err), 32'h1);
      cyc(4'b0000, 1'b0, 1'b1, 1'b0);
      chk("race_clear", 32'(phase_err), 32'h0);

      // Reset mid-word
      for (int i = 0; i < 5; i++) period(1'($urandom_range(0, 1)));
      chk("mid_count", 32'(bit_count), 32'd5);
      v0 = vcount;
      repeat (2) cyc(4'b0000, 1'b0, 1'b0, 1'b1);
      chk("mid_rst_count", 32'(bit_count), 32'h0);
      chk("mid_no_valid", 32'(vcount - v0), 32'd0);
      for (int i = 0; i < W; i++) period(1'b1);
      chk("mid_word", 32'(word_out), 32'hFF);
      chk("mid_pulses", 32'(vcount - v0), 32'd1);

      // Random soak with sparse toggles, clears and resets
      lvl_r = 4'b0000;
      for (int k = 0; k < 400; k++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 5) == 0) lvl_r[b] = ~lvl_r[b];
         end
         cyc(lvl_r, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 99) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
